// File: rtl/frog_game_controller.sv
// Frog game sequencer: scans cars through one shared collision checker each frame
// and runs the start/play/death/win/game-over flow, keeping lives and level.
module frog_game_controller #(
    parameter int NUM_CARS     = 4,
    parameter int IDX_W        = 2,
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 30,
    parameter int WIN_FRAMES   = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             start_btn,
    input  logic             death_collision,
    input  logic             win_collision,
    output logic [IDX_W-1:0] car_sel,
    output logic             scan_active,
    output logic             freeze,
    output logic             frog_reset,
    output logic [1:0]       lives,
    output logic [3:0]       level,
    output logic             game_over,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_SCAN      = 3'd2,
        S_DYING     = 3'd3,
        S_WON       = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_CAR    = IDX_W'(NUM_CARS - 1);
    localparam logic [1:0]       LIVES_START = 2'(LIVES_INIT);
    localparam logic [7:0]       DEATH_LAST  = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0]       WIN_LAST    = 8'(WIN_FRAMES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] car_sel_q, car_sel_d;
    logic             scan_active_q, scan_active_d;
    logic             freeze_q, freeze_d;
    logic             frog_reset_q, frog_reset_d;
    logic [1:0]       lives_q, lives_d;
    logic [3:0]       level_q, level_d;
    logic             game_over_q, game_over_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             death_hit_q, death_hit_d;
    logic             win_hit_q, win_hit_d;

    always_comb begin
        state_d       = state_q;
        car_sel_d     = car_sel_q;
        scan_active_d = scan_active_q;
        freeze_d      = freeze_q;
        frog_reset_d  = 1'b0;
        lives_d       = lives_q;
        level_d       = level_q;
        game_over_d   = game_over_q;
        frame_cnt_d   = frame_cnt_q;
        death_hit_d   = death_hit_q;
        win_hit_d     = win_hit_q;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                freeze_d    = 1'b1;
                game_over_d = (state_q == S_GAME_OVER);
                if (start_btn) begin
                    state_d      = S_PLAY;
                    lives_d      = LIVES_START;
                    level_d      = 4'd0;
                    frog_reset_d = 1'b1;
                    freeze_d     = 1'b0;
                    game_over_d  = 1'b0;
                end
            end
            S_PLAY: begin
                freeze_d = 1'b0;
                if (frame_tick) begin
                    state_d       = S_SCAN;
                    car_sel_d     = '0;
                    scan_active_d = 1'b1;
                    death_hit_d   = 1'b0;
                    win_hit_d     = 1'b0;
                end
            end
            S_SCAN: begin
                // Fold in this cycle's checker result so the last car counts.
                death_hit_d = death_hit_q | death_collision;
                win_hit_d   = win_hit_q | win_collision;
                if (car_sel_q == LAST_CAR) begin
                    scan_active_d = 1'b0;
                    car_sel_d     = '0;
                    frame_cnt_d   = 8'd0;
                    if (death_hit_d) begin
                        state_d  = S_DYING;
                        lives_d  = lives_q - 2'd1;
                        freeze_d = 1'b1;
                    end else if (win_hit_d) begin
                        state_d  = S_WON;
                        freeze_d = 1'b1;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    car_sel_d = car_sel_q + 1'b1;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (frame_cnt_q == DEATH_LAST) begin
                        if (lives_q == 2'd0) begin
                            state_d     = S_GAME_OVER;
                            game_over_d = 1'b1;
                            freeze_d    = 1'b1;
                        end else begin
                            state_d      = S_PLAY;
                            frog_reset_d = 1'b1;
                            freeze_d     = 1'b0;
                        end
                    end
                end
            end
            S_WON: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (frame_cnt_q == WIN_LAST) begin
                        level_d      = (level_q == 4'hF) ? level_q : level_q + 4'd1;
                        state_d      = S_PLAY;
                        frog_reset_d = 1'b1;
                        freeze_d     = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            car_sel_q     <= '0;
            scan_active_q <= 1'b0;
            freeze_q      <= 1'b1;
            frog_reset_q  <= 1'b0;
            lives_q       <= LIVES_START;
            level_q       <= 4'd0;
            game_over_q   <= 1'b0;
            frame_cnt_q   <= 8'd0;
            death_hit_q   <= 1'b0;
            win_hit_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            car_sel_q     <= car_sel_d;
            scan_active_q <= scan_active_d;
            freeze_q      <= freeze_d;
            frog_reset_q  <= frog_reset_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            game_over_q   <= game_over_d;
            frame_cnt_q   <= frame_cnt_d;
            death_hit_q   <= death_hit_d;
            win_hit_q     <= win_hit_d;
        end
    end

    assign car_sel     = car_sel_q;
    assign scan_active = scan_active_q;
    assign freeze      = freeze_q;
    assign frog_reset  = frog_reset_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign game_over   = game_over_q;
    assign state       = state_q;

endmodule

// File: doc/frog_game_controller.md
Name: frog_game_controller

Overview:
- Top-level game sequencer for the frog game.
- Time-multiplexes one shared frog-vs-car collision checker across NUM_CARS cars once per video frame, and drives the selected car via car_sel.
- Runs the game state machine: start, play, death freeze, win freeze and game over. Maintains lives and level, and issues the frog respawn pulse and the global freeze that movement logic obeys.

Parameters:
- NUM_CARS, 4, number of cars scanned per frame (1..16).
- IDX_W, 2, width of car_sel; must satisfy 2^IDX_W >= NUM_CARS.
- LIVES_INIT, 3, lives loaded at game start (1..3).
- DEATH_FRAMES, 30, frames frozen after a death (1..255).
- WIN_FRAMES, 30, frames frozen after reaching the top row (1..255).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- start_btn  in  1  one-cycle, already-debounced start pulse.
- death_collision  in  1  result of the shared checker for the car currently on car_sel (combinational, same cycle).
- win_collision  in  1  frog-at-top-row flag from the shared checker.
- car_sel  out  IDX_W  index of the car fed to the checker.
- scan_active  out  1  high while a scan is in progress.
- freeze  out  1  halts frog and car motion.
- frog_reset  out  1  one-cycle pulse: return frog to its spawn tile.
- lives  out  2  remaining lives.
- level  out  4  current level; saturates at 15.
- game_over  out  1  high in GAME_OVER.
- state  out  3  encoded state for debug and HUD: IDLE=0, PLAY=1, SCAN=2, DYING=3, WON=4, GAME_OVER=5.

Behaviour:
- Reset (async assert, sync release): state=IDLE, car_sel=0, scan_active=0, freeze=1, frog_reset=0, lives=LIVES_INIT, level=0, game_over=0, internal counters and hit flags cleared.
- All outputs are registered.
- IDLE:
  - freeze=1.
  - start_btn → next cycle: state=PLAY, lives=LIVES_INIT, level=0, frog_reset=1 for 1 cycle, freeze=0.
- PLAY:
  - freeze=0.
  - frame_tick → next cycle: state=SCAN, car_sel=0, scan_active=1, death and win hit flags cleared.
- SCAN:
  - Lasts exactly NUM_CARS cycles; car_sel steps 0,1,…,NUM_CARS-1.
  - Every cycle: death_hit |= death_collision; win_hit |= win_collision.
  - The last cycle's inputs are included in the decision.
  - On the cycle after car_sel=NUM_CARS-1: scan_active=0, car_sel=0, and the next state is chosen as follows:
    - death_hit → DYING, lives decremented by 1, freeze=1.
    - else win_hit → WON, freeze=1.
    - else → PLAY.
  - Death has priority when death and win hit in the same scan.
  - frame_tick and start_btn during SCAN are ignored.
- DYING:
  - Counts frame_tick pulses.
  - On the DEATH_FRAMES-th tick:
    - lives==0 → GAME_OVER (freeze stays 1, game_over=1).
    - otherwise → PLAY, frog_reset pulse, freeze=0.
- WON:
  - Counts frame_tick pulses.
  - On the WIN_FRAMES-th tick: level+1 (held at 15 when already 15), frog_reset pulse, → PLAY, freeze=0.
- GAME_OVER:
  - freeze=1, game_over=1.
  - start_btn → same actions as start from IDLE; game_over=0.
- start_btn in PLAY, DYING or WON: ignored.
- lives never underflows: decrement happens only when entering DYING, which requires lives ≥ 1.
- Frame counter is 8 bits and is cleared on entry to DYING and WON.
- reset asserted mid-scan or mid-freeze: immediate return to reset values; no frog_reset pulse is generated.

Test Plan:
- Reset then start_btn → after 1 cycle: state=PLAY, lives=3, level=0, frog_reset high exactly 1 cycle, freeze=0.
- PLAY, frame_tick, no hits → scan_active high 4 cycles with car_sel 0,1,2,3, then state=PLAY, lives unchanged.
- PLAY, frame_tick, death_collision high only while car_sel=3 → state=DYING, lives=2, freeze=1. After 30 frame_ticks: frog_reset pulse, state=PLAY.
- Death and win both asserted in the same scan → DYING taken, level unchanged. A separate win-only scan → WON; after 30 ticks level=1. With level=15, a further win → level stays 15.
- Three deaths from lives=3 → after the third DYING period: state=GAME_OVER, game_over=1, no frog_reset. Then start_btn → lives=3, level=0, state=PLAY.
- Assert reset while car_sel=2 in SCAN → outputs at reset values immediately, state=IDLE. A start_btn during SCAN or DYING (without reset) has no effect.
